imem_boot: RTL and testbench

//  Instruction-memory responder with byte-stream boot loader. Serves the fetch unit's
//  12-bit inst_addr with an 8-bit instruction in the same cycle (combinational read),
//  so fetch captures it on that cycle's clock edge. Also accepts a host byte stream
//  (valid/ready) that writes a program image from address 0. Holds the CPU in reset
//  via cpu_reset_ until a load completes.

---
 rtl/imem_boot.sv | 201 ++++++++++++++++++++
 tb/tb_imem_boot.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot.sv
// -----------------------------------------------------------------------------
// imem_boot
//   Instruction memory with a byte-stream boot loader.
//
//   The fetch unit presents inst_addr and receives the addressed byte on inst
//   in the same cycle (combinational read), so fetch captures it on that
//   cycle's clock edge. A host streams a program image over a valid/ready
//   byte interface:
//     byte 0 : len[7:0]
//     byte 1 : len[11:8] in bits [3:0], bits [7:4] ignored
//     then len+1 data bytes written from address 0 upward
//     then (checksum build only) one byte = modulo-256 sum of the data bytes
//   The CPU is held in reset (cpu_reset_ low) until a load completes.
//
//   Build option: define IMEM_CHECKSUM_EN to enable the trailing checksum
//   byte, the ERR state and the sticky load_err flag. Without it load_err is
//   tied low and the last data byte goes straight to RUN.
//
// Ports
//   clk         in   core clock
//   reset_      in   asynchronous active-low reset
//   inst_addr   in   [ADDR_W] fetch address
//   inst        out  [DATA_W] instruction, 0 unless running
//   ld_start    in   pulse: begin a new image load (honoured in IDLE/RUN/ERR)
//   ld_valid    in   host byte valid
//   ld_data     in   [DATA_W] host byte
//   ld_ready    out  loader accepts a byte this cycle
//   cpu_reset_  out  active-low CPU reset, high only while running
//   load_busy   out  load in progress
//   load_done   out  one-cycle pulse on entering RUN
//   load_err    out  sticky checksum error
// -----------------------------------------------------------------------------
module imem_boot #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              cpu_reset_,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

`ifdef IMEM_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CHK, S_RUN, S_ERR
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_RUN
  } state_e;
`endif

  state_e            state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              cpu_reset_q;
  logic              load_done_q;
  logic              xfer;

  logic [DATA_W-1:0] mem [DEPTH];

  // Ready depends on state only, never on ld_valid, so the host may hold
  // valid high without creating a combinational loop through the handshake.
  always_comb begin
    load_busy = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA)
`ifdef IMEM_CHECKSUM_EN
             || (state_q == S_CHK)
`endif
             ;
  end

  assign ld_ready   = load_busy;
  assign xfer       = ld_valid & ld_ready;
  assign cpu_reset_ = cpu_reset_q;
  assign load_done  = load_done_q;

  // Same-cycle write and read of one address returns the old contents; the
  // CPU is held in reset during a load, so that is never observed in use.
  assign inst = (state_q == S_RUN) ? mem[inst_addr] : '0;

  // NOTE: the memory array has no reset: untouched locations must keep their
  // prior contents across reloads and a reset mid-load, and a reset on a
  // large array would prevent it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && xfer) begin
      mem[wr_addr_q] <= ld_data;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              load_err_q;
  assign load_err = load_err_q;
`else
  assign load_err = 1'b0;
`endif

  // NOTE: every register here is state, so all updates use non-blocking
  // assignments; blocking ones would let later statements see new values.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wr_addr_q   <= '0;
      cnt_q       <= '0;
      cpu_reset_q <= 1'b0;
      load_done_q <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      sum_q       <= '0;
      load_err_q  <= 1'b0;
`endif
    end else begin
      load_done_q <= 1'b0;
      // Follows the state one cycle late: releases the cycle after RUN is
      // entered and asserts the cycle after RUN is left.
      cpu_reset_q <= (state_q == S_RUN);

      case (state_q)
        S_IDLE: begin
          if (ld_start) state_q <= S_HDR0;
        end

        S_HDR0: begin
          if (xfer) begin
            len_q[DATA_W-1:0] <= ld_data;
            state_q           <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (xfer) begin
            // Only the low nibble carries length; the rest of the byte is ignored.
            len_q[ADDR_W-1:DATA_W] <= ld_data[ADDR_W-DATA_W-1:0];
            wr_addr_q              <= '0;
            cnt_q                  <= '0;
`ifdef IMEM_CHECKSUM_EN
            sum_q                  <= '0;
`endif
            state_q                <= S_DATA;
          end
        end

        S_DATA: begin
          if (xfer) begin
            // A full 4096-byte image wraps wr_addr to 0; the FSM leaves DATA on
            // the same edge, so the wrapped address is never written.
            wr_addr_q <= wr_addr_q + 1'b1;
            cnt_q     <= cnt_q + 1'b1;
`ifdef IMEM_CHECKSUM_EN
            sum_q     <= sum_q + ld_data;
            if (cnt_q == len_q) state_q <= S_CHK;
`else
            if (cnt_q == len_q) begin
              state_q     <= S_RUN;
              load_done_q <= 1'b1;
            end
`endif
          end
        end

`ifdef IMEM_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            if (ld_data == sum_q) begin
              state_q     <= S_RUN;
              load_done_q <= 1'b1;
            end else begin
              state_q     <= S_ERR;
              load_err_q  <= 1'b1;
            end
          end
        end

        S_ERR: begin
          if (ld_start) begin
            load_err_q <= 1'b0;
            state_q    <= S_HDR0;
          end
        end
`endif

        S_RUN: begin
          if (ld_start) state_q <= S_HDR0;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot.sv
module tb_imem_boot;

  logic        clk       = 1'b0;
  logic        reset_    = 1'b0;
  logic [11:0] inst_addr = '0;
  logic [7:0]  inst;
  logic        ld_start  = 1'b0;
  logic        ld_valid  = 1'b0;
  logic [7:0]  ld_data   = '0;
  logic        ld_ready;
  logic        cpu_reset_;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  logic [7:0] model [4096];   // reference image of written locations
  logic [7:0] img   [$];      // data bytes of the image being sent
  logic [7:0] exp_q [$];      // scoreboard of expected inst values

  imem_boot dut (
    .clk        (clk),
    .reset_     (reset_),
    .inst_addr  (inst_addr),
    .inst       (inst),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .cpu_reset_ (cpu_reset_),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    ld_valid = 1'b0;
    repeat (gap) @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = b;
    while (!ld_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) begin
      cmp_cnt++;
      mis_cnt++;
      $display("FAIL send_byte_ready: got ld_ready=0 expected 1 within 20 cycles");
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  // Drives inst_addr, pushes the expected inst, pops and compares after settle.
  task automatic check_range(input int lo, input int n, input bit running, input string tag);
    logic [11:0] a;
    logic [7:0]  e;
    for (int i = 0; i < n; i++) begin
      a = 12'(lo + i);
      inst_addr = a;
      exp_q.push_back(running ? model[a] : 8'h00);
      #1;
      e = exp_q.pop_front();
      cmp_cnt++;
      if (inst !== e) begin
        mis_cnt++;
        $display("FAIL %s_inst[%h]: got %h expected %h", tag, a, inst, e);
      end
      @(negedge clk);
    end
  endtask

  // Full load of img from address 0, with optional valid gaps and a
  // mid-DATA ld_start pulse that must be ignored.
  task automatic load_image(input int gap, input bit start_mid, input string tag);
    int         len;
    logic [7:0] sum;
    len = img.size() - 1;
    sum = '0;
    pulse_start();
    send_byte(len[7:0], gap);
    send_byte({4'hA, len[11:8]}, gap);
    for (int i = 0; i < img.size(); i++) begin
      if (start_mid && i == img.size() / 2) begin
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
      end
      send_byte(img[i], gap);
      model[i] = img[i];
      sum = sum + img[i];
    end
`ifdef IMEM_CHECKSUM_EN
    send_byte(sum, gap);
`endif
    cmp_cnt++;
    if ({load_done, cpu_reset_, load_busy} !== 3'b100) begin
      mis_cnt++;
      $display("FAIL %s_enter_run: got done/cpu_rst_/busy=%b expected 100", tag,
               {load_done, cpu_reset_, load_busy});
    end
    @(negedge clk);
    cmp_cnt++;
    if ({load_done, cpu_reset_, ld_ready} !== 3'b010) begin
      mis_cnt++;
      $display("FAIL %s_release: got done/cpu_rst_/ready=%b expected 010", tag,
               {load_done, cpu_reset_, ld_ready});
    end
  endtask

  task automatic test_reset();
    #1;
    cmp_cnt++;
    if ({inst, ld_ready, cpu_reset_, load_busy, load_done, load_err} !== 13'h0) begin
      mis_cnt++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {inst, ld_ready, cpu_reset_, load_busy, load_done, load_err});
    end
    @(negedge clk);
    reset_ = 1'b1;
    ld_valid = 1'b1;          // must be ignored in IDLE
    ld_data  = 8'h5A;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if ({ld_ready, cpu_reset_, load_busy} !== 3'b000) begin
      mis_cnt++;
      $display("FAIL idle_outputs: got ready/cpu_rst_/busy=%b expected 000",
               {ld_ready, cpu_reset_, load_busy});
    end
    ld_valid = 1'b0;
    check_range(0, 2, 1'b0, "idle");
    check_range(12'hFFF, 1, 1'b0, "idle");
  endtask

  task automatic test_load();
    img = '{8'hA1, 8'hB2, 8'hC3};
    load_image(0, 1'b0, "load");
    check_range(1, 1, 1'b1, "load");
    check_range(0, 3, 1'b1, "load");
    // Host bytes while running are not accepted.
    ld_valid = 1'b1;
    ld_data  = 8'hEE;
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if ({ld_ready, cpu_reset_} !== 2'b01) begin
      mis_cnt++;
      $display("FAIL run_ignores_valid: got ready/cpu_rst_=%b expected 01", {ld_ready, cpu_reset_});
    end
    ld_valid = 1'b0;
    check_range(0, 3, 1'b1, "run_hold");
  endtask

  task automatic test_gaps();
    img = '{8'h55, 8'h66, 8'h77};
    load_image(0, 1'b0, "pre_gap");
    check_range(0, 3, 1'b1, "pre_gap");
    img = '{8'hA1, 8'hB2, 8'hC3};
    load_image(1, 1'b1, "gap");
    check_range(0, 3, 1'b1, "gap");
  endtask

  task automatic test_full();
    img.delete();
    for (int i = 0; i < 4096; i++) img.push_back(8'((i * 13 + 7) ^ (i >> 8)));
    load_image(0, 1'b0, "full");
    check_range(0, 4, 1'b1, "full");
    check_range(12'h800, 1, 1'b1, "full");
    check_range(12'hFFE, 2, 1'b1, "full");
    img = '{8'h11, 8'h22, 8'h33};
    load_image(0, 1'b0, "reload");
    check_range(0, 6, 1'b1, "reload");
    check_range(12'h800, 1, 1'b1, "reload");
    check_range(12'hFFF, 1, 1'b1, "reload");
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_byte(8'h9A, 0); model[0] = 8'h9A;
    send_byte(8'h9B, 0); model[1] = 8'h9B;
    #2;
    reset_ = 1'b0;
    #1;
    cmp_cnt++;
    if ({ld_ready, load_busy, cpu_reset_, load_done, load_err, inst} !== 13'h0) begin
      mis_cnt++;
      $display("FAIL reset_mid_outputs: got %h expected 0000",
               {ld_ready, load_busy, cpu_reset_, load_done, load_err, inst});
    end
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if (ld_ready !== 1'b0) begin
      mis_cnt++;
      $display("FAIL reset_mid_idle: got ld_ready=%b expected 0", ld_ready);
    end
    img = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    load_image(0, 1'b0, "after_rst");
    check_range(0, 6, 1'b1, "after_rst");
  endtask

`ifdef IMEM_CHECKSUM_EN
  task automatic test_checksum();
    img = '{8'h10, 8'h20};
    load_image(0, 1'b0, "chk_ok");
    check_range(0, 2, 1'b1, "chk_ok");
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h31, 0);
    @(negedge clk);
    cmp_cnt++;
    if ({load_err, cpu_reset_, ld_ready, load_done, inst} !== 12'h800) begin
      mis_cnt++;
      $display("FAIL chk_err: got err/cpu_rst_/ready/done/inst=%h expected 800",
               {load_err, cpu_reset_, ld_ready, load_done, inst});
    end
    pulse_start();
    cmp_cnt++;
    if ({load_err, load_busy} !== 2'b01) begin
      mis_cnt++;
      $display("FAIL chk_clear: got err/busy=%b expected 01", {load_err, load_busy});
    end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h40, 0); model[0] = 8'h40;
    send_byte(8'h50, 0); model[1] = 8'h50;
    send_byte(8'h90, 0);
    @(negedge clk);
    cmp_cnt++;
    if ({cpu_reset_, load_err} !== 2'b10) begin
      mis_cnt++;
      $display("FAIL chk_recover: got cpu_rst_/err=%b expected 10", {cpu_reset_, load_err});
    end
    check_range(0, 2, 1'b1, "chk_recover");
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_gaps();
    test_full();
    test_reset_mid();
`ifdef IMEM_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
